tcam: RTL and testbench
=======================

TCAM -- requirements
Module: tcam

Interface
REQ-001 The block SHALL have parameter TCAM_WIDTH, default 32, meaning key/entry width in bits.
REQ-002 The block SHALL have parameter TCAM_DEPTH, default 16, meaning number of entries.
REQ-003 The block SHALL have derived localparam TCAM_INDEX_WIDTH = $clog2(TCAM_DEPTH), meaning entry index width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 data_we  input  1  1 = write entry; 0 = search request (when data_vld=1).
REQ-008 data_vld  input  1  on write: valid bit stored for the entry; on non-write: search enable.
REQ-009 data_idx  input  TCAM_INDEX_WIDTH  entry index for writes; ignored on search.
REQ-010 data_i  input  TCAM_WIDTH  entry data on write; search key on search.
REQ-011 data_mask  input  TCAM_WIDTH  entry mask on write, 1 = don't-care bit; ignored on search.
REQ-012 index_rdy  output  1  registered hit strobe for the previous cycle's search.
REQ-013 index_o  output  TCAM_INDEX_WIDTH  registered index of the matching entry.

Function
REQ-014 Each entry SHALL hold data[TCAM_WIDTH], mask[TCAM_WIDTH] and a valid bit.
REQ-015 Write: on a rising edge with data_we=1 and rst=0, entry[data_idx] SHALL load data_i, data_mask and data_vld. Writing data_vld=0 invalidates the entry.
REQ-016 A write with data_idx >= TCAM_DEPTH SHALL be ignored.
REQ-017 Search: on a rising edge with data_we=0, data_vld=1 and rst=0, every entry SHALL be compared in parallel.
REQ-018 Entry i SHALL match when valid[i]=1 and ((data_i ^ data[i]) & ~mask[i]) == 0.
REQ-019 Priority: when several entries match, the lowest index SHALL win.
REQ-020 Latency: one cycle. If the search hits, index_rdy=1 and index_o=winning index in the cycle after the request edge.
REQ-021 On a search miss, index_rdy SHALL be 0 in the following cycle and index_o SHALL hold its previous value.
REQ-022 In any cycle with no search request (data_we=1, or data_vld=0), index_rdy SHALL be 0 in the following cycle and index_o SHALL hold.
REQ-023 index_rdy SHALL be a single-cycle pulse per hitting search; back-to-back searches SHALL produce back-to-back results at one per cycle.
REQ-024 Write-then-search: a search issued in the cycle after a write SHALL see the updated entry.
REQ-025 Write and search cannot coincide because data_we selects the operation; the write takes effect and no search occurs.
REQ-026 An all-ones mask SHALL match any key; an all-zeros mask SHALL give exact-match (binary CAM) behaviour.
REQ-027 Outputs SHALL come directly from flops; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-028 While rst=1 at a rising edge, all valid bits SHALL clear and index_rdy and index_o SHALL be set to 0.
REQ-029 While rst=1 at a rising edge, writes and searches presented in that cycle SHALL be ignored.
REQ-030 Entry data and mask contents need not be reset.
REQ-031 A reset asserted mid-operation SHALL discard any pending result: index_rdy=0 in the cycle after the reset edge.
REQ-032 After reset deasserts, the first search SHALL miss until entries are written.

Verification
REQ-033 Reset, then search key 0x00000000 -> index_rdy=0, index_o=0.
REQ-034 Write idx 3 data 0x12345678 mask 0 vld 1; next cycle search 0x12345678 -> next cycle index_rdy=1, index_o=3. Search 0x12345679 -> index_rdy=0.
REQ-035 Write idx 5 data 0xABCD0000 mask 0x0000FFFF and idx 9 data 0xABCD1234 mask 0; search 0xABCD1234 -> index_o=5 (lowest index wins). Then invalidate idx 5 (vld 0) and search again -> index_o=9.
REQ-036 Write idx 15 mask 0xFFFFFFFF vld 1; search 0xDEADBEEF -> index_o=15. Search 0xDEADBEEF with data_vld=0 -> index_rdy=0.
REQ-037 Back-to-back searches 0x12345678, 0xDEADBEEF, 0x11111111 on consecutive cycles with idx 3 and idx 15 programmed as above (no other entries valid) -> results on consecutive cycles: 3, 15, 15.
REQ-038 Assert rst for one cycle between a search request and its result cycle -> index_rdy=0; a subsequent search of 0x12345678 misses.

Source files
------------

// File: rtl/tcam_if.sv
// -----------------------------------------------------------------------------
// tcam_if -- request/result bundle for the ternary CAM.
//
// Signals
//   data_we    1 = write entry, 0 = search request (when data_vld = 1)
//   data_vld   write: valid bit stored for the entry; search: search enable
//   data_idx   entry index for writes (ignored on search)
//   data_i     entry data on write, search key on search
//   data_mask  entry mask on write (1 = don't-care bit), ignored on search
//   index_rdy  registered hit strobe for the previous cycle's search
//   index_o    registered index of the winning entry
//
// Modports
//   master  drives requests, receives results (client / testbench)
//   slave   receives requests, drives results (the tcam)
// -----------------------------------------------------------------------------
interface tcam_if #(
  parameter int TCAM_WIDTH = 32,
  parameter int TCAM_DEPTH = 16
);
  localparam int TCAM_INDEX_WIDTH = $clog2(TCAM_DEPTH);

  logic                        data_we;
  logic                        data_vld;
  logic [TCAM_INDEX_WIDTH-1:0] data_idx;
  logic [TCAM_WIDTH-1:0]       data_i;
  logic [TCAM_WIDTH-1:0]       data_mask;
  logic                        index_rdy;
  logic [TCAM_INDEX_WIDTH-1:0] index_o;

  modport master (
    output data_we, data_vld, data_idx, data_i, data_mask,
    input  index_rdy, index_o
  );

  modport slave (
    input  data_we, data_vld, data_idx, data_i, data_mask,
    output index_rdy, index_o
  );
endinterface

// File: rtl/tcam.sv
// -----------------------------------------------------------------------------
// tcam -- ternary content-addressable memory with one-cycle search latency.
//
// Each entry holds data, a don't-care mask and a valid bit. A search compares
// the key against every entry in parallel; the lowest matching index wins and
// is reported, registered, in the following cycle.
//
// Ports
//   clk  rising-edge clock for all state
//   rst  synchronous active-high reset (clears valid bits and outputs)
//   bus  tcam_if.slave request/result bundle (see tcam_if.sv)
// -----------------------------------------------------------------------------
module tcam #(
  parameter int TCAM_WIDTH = 32,
  parameter int TCAM_DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst,
  tcam_if.slave  bus
);
  localparam int TCAM_INDEX_WIDTH = $clog2(TCAM_DEPTH);
  // One extra bit so the bound check also works when TCAM_DEPTH is not a
  // power of two and data_idx can name a nonexistent entry.
  localparam logic [TCAM_INDEX_WIDTH:0] DEPTH_LIMIT = (TCAM_INDEX_WIDTH + 1)'(TCAM_DEPTH);

  logic [TCAM_WIDTH-1:0]       ent_data [TCAM_DEPTH];
  logic [TCAM_WIDTH-1:0]       ent_mask [TCAM_DEPTH];
  logic [TCAM_DEPTH-1:0]       ent_valid;

  logic                        write_en;
  logic                        search_en;
  logic [TCAM_DEPTH-1:0]       match_vec;
  logic                        hit;
  logic [TCAM_INDEX_WIDTH-1:0] hit_idx;

  assign write_en  = bus.data_we && ({1'b0, bus.data_idx} < DEPTH_LIMIT);
  assign search_en = !bus.data_we && bus.data_vld;

  // Valid bits are the only entry state that must come out of reset clean.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its inputs, independent of statement order.
    if (rst) begin
      ent_valid <= '0;
    end else if (write_en) begin
      ent_valid[bus.data_idx] <= bus.data_vld;
    end
  end

  // NOTE: the entry storage deliberately has no reset branch; contents are
  // meaningless while the valid bit is clear, and a reset-free array can map
  // onto plain RAM/flop banks without a clear network.
  always_ff @(posedge clk) begin
    if (!rst && write_en) begin
      ent_data[bus.data_idx] <= bus.data_i;
      ent_mask[bus.data_idx] <= bus.data_mask;
    end
  end

  // Parallel compare: an entry matches when every cared-for bit agrees.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    match_vec = '0;
    for (int i = 0; i < TCAM_DEPTH; i++) begin
      match_vec[i] = ent_valid[i] &&
                     (((bus.data_i ^ ent_data[i]) & ~ent_mask[i]) == '0);
    end
  end

  // Priority encoder: scanning high to low lets the lowest index overwrite
  // any higher one, so the lowest matching entry wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = TCAM_DEPTH - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        // NOTE: blocking (=) in combinational logic, so the later (lower)
        // index seen in this loop is the value that survives.
        hit     = 1'b1;
        hit_idx = TCAM_INDEX_WIDTH'(i);
      end
    end
  end

  // Result registers: strobe only on a hitting search, index holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.index_rdy <= 1'b0;
      bus.index_o   <= '0;
    end else begin
      bus.index_rdy <= search_en && hit;
      if (search_en && hit) begin
        bus.index_o <= hit_idx;
      end
    end
  end
endmodule

// File: tb/tb_tcam.sv
// -----------------------------------------------------------------------------
// tb_tcam -- self-checking bench for tcam.
// A table-based model (plain arrays, first-match search) predicts the outputs;
// a negedge process compares DUT against it every cycle after the first reset.
// Directed steps additionally pin both DUT and model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_tcam;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int IW = $clog2(D);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tcam_if #(.TCAM_WIDTH(W), .TCAM_DEPTH(D)) bus ();

  tcam #(.TCAM_WIDTH(W), .TCAM_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0]  m_data  [D];
  logic [W-1:0]  m_mask  [D];
  bit            m_valid [D];
  logic          exp_rdy;
  logic [IW-1:0] exp_idx;
  bit            cmp_en = 1'b0;

  // True when every bit is either don't-care in the entry or equal to the key.
  function automatic bit entry_matches(input int e, input logic [W-1:0] key);
    for (int b = 0; b < W; b++) begin
      if (!m_mask[e][b] && (m_data[e][b] != key[b])) return 1'b0;
    end
    return m_valid[e];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
      exp_rdy = 1'b0;
      exp_idx = '0;
    end else if (bus.data_we) begin
      if (int'(bus.data_idx) < D) begin
        m_data[bus.data_idx]  = bus.data_i;
        m_mask[bus.data_idx]  = bus.data_mask;
        m_valid[bus.data_idx] = bus.data_vld;
      end
      exp_rdy = 1'b0;
    end else if (bus.data_vld) begin
      exp_rdy = 1'b0;
      for (int i = 0; i < D; i++) begin
        if (entry_matches(i, bus.data_i)) begin
          exp_rdy = 1'b1;
          exp_idx = IW'(i);
          break;
        end
      end
    end else begin
      exp_rdy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_rdy", 32'(bus.index_rdy), 32'(exp_rdy));
      check("cyc_idx", 32'(bus.index_o),   32'(exp_idx));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic op(input logic r, input logic we, input logic vld,
                    input logic [IW-1:0] idx, input logic [W-1:0] d, input logic [W-1:0] m);
    rst           = r;
    bus.data_we   = we;
    bus.data_vld  = vld;
    bus.data_idx  = idx;
    bus.data_i    = d;
    bus.data_mask = m;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic [W-1:0] d, input logic [W-1:0] m, input logic vld);
    op(1'b0, 1'b1, vld, IW'(idx), d, m);
  endtask

  task automatic srch(input logic [W-1:0] key);
    op(1'b0, 1'b0, 1'b1, IW'($urandom), key, $urandom);
  endtask

  // Pin both DUT and model to a hand-computed result.
  task automatic expect_out(input string name, input logic rdy, input int idx);
    check({name, "_rdy"},   32'(bus.index_rdy), 32'(rdy));
    check({name, "_idx"},   32'(bus.index_o),   32'(idx));
    check({name, "_model"}, {31'(exp_idx), exp_rdy}, {31'(idx), rdy});
  endtask

  initial begin
    for (int i = 0; i < D; i++) begin
      m_data[i]  = '0;
      m_mask[i]  = '0;
      m_valid[i] = 1'b0;
    end
    op(1'b1, 1'b0, 1'b0, '0, '0, '0);
    cmp_en = 1'b1;
    op(1'b1, 1'b0, 1'b1, '0, '0, '0);

    // Reset then search: miss, index 0.
    srch(32'h0000_0000);                       expect_out("post_reset", 1'b0, 0);

    // Exact match and one-bit-off miss (index holds).
    wr(3, 32'h1234_5678, 32'h0, 1'b1);
    srch(32'h1234_5678);                       expect_out("exact_hit", 1'b1, 3);
    srch(32'h1234_5679);                       expect_out("exact_miss", 1'b0, 3);

    // Priority between a ternary and an exact entry, then invalidation.
    wr(5, 32'hABCD_0000, 32'h0000_FFFF, 1'b1);
    wr(9, 32'hABCD_1234, 32'h0, 1'b1);
    srch(32'hABCD_1234);                       expect_out("prio_low", 1'b1, 5);
    wr(5, 32'hABCD_0000, 32'h0000_FFFF, 1'b0);
    srch(32'hABCD_1234);                       expect_out("after_inval", 1'b1, 9);

    // All-ones mask matches anything; data_vld=0 is no search.
    wr(15, 32'h0, 32'hFFFF_FFFF, 1'b1);
    srch(32'hDEAD_BEEF);                       expect_out("wildcard", 1'b1, 15);
    op(1'b0, 1'b0, 1'b0, '0, 32'hDEAD_BEEF, '0); expect_out("no_search", 1'b0, 15);

    // Back-to-back searches with only 3 and 15 valid.
    wr(9, 32'h0, 32'h0, 1'b0);                 expect_out("write_cycle", 1'b0, 15);
    srch(32'h1234_5678);                       expect_out("b2b_0", 1'b1, 3);
    srch(32'hDEAD_BEEF);                       expect_out("b2b_1", 1'b1, 15);
    srch(32'h1111_1111);                       expect_out("b2b_2", 1'b1, 15);

    // Reset on the search edge discards the result and clears entries.
    srch(32'h1234_5678);                       expect_out("pre_rst_hit", 1'b1, 3);
    op(1'b1, 1'b0, 1'b1, '0, 32'h1234_5678, '0); expect_out("rst_discard", 1'b0, 0);
    srch(32'h1234_5678);                       expect_out("rst_then_miss", 1'b0, 0);

    // Fill every entry so random keys never meet undefined storage.
    for (int i = 0; i < D; i++) wr(i, $urandom, 32'h0, 1'b1);

    // Randomized phase: mixed writes, searches, idles and rare resets.
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = $urandom_range(0, 299);
      if (sel == 0) begin
        op(1'b1, 1'($urandom), 1'($urandom), IW'($urandom), $urandom, $urandom);
      end else if (sel < 90) begin
        logic [W-1:0] m;
        int mk;
        mk = $urandom_range(0, 29);
        if (mk == 0)      m = '1;
        else if (mk < 15) m = '0;
        else              m = $urandom & $urandom & $urandom;
        wr($urandom_range(0, D - 1), $urandom, m, ($urandom_range(0, 5) != 0));
      end else if (sel < 270) begin
        logic [W-1:0] key;
        int j;
        j = $urandom_range(0, D - 1);
        if ($urandom_range(0, 3) != 0) key = m_data[j] ^ ($urandom & m_mask[j]);
        else                           key = $urandom;
        srch(key);
      end else begin
        op(1'b0, 1'b0, 1'b0, IW'($urandom), $urandom, $urandom);
      end
    end

    op(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
